// File: rtl/r_type_instr_feeder.sv
// Instruction-side responder for the darkriscv fetch port: accepts R-type
// instruction fields over a valid/ready load port, encodes and stores them,
// then serves them to the core by fetch address with one-cycle latency.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_LOAD | core halted, program entries accepted while count < DEPTH
// ST_RUN  | core running, in-range fetches return stored words
// ST_DONE | core fetched past the program end; NOPs only, counter frozen
module r_type_instr_feeder #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RES_N,
   input  logic        LD_VALID,
   output logic        LD_READY,
   input  logic [6:0]  LD_FUNCT7,
   input  logic [2:0]  LD_FUNCT3,
   input  logic [4:0]  LD_RS1,
   input  logic [4:0]  LD_RS2,
   input  logic [4:0]  LD_RD,
   input  logic        LD_LAST,
   output logic        LD_ERR,
   input  logic        RESTART,
   input  logic [31:0] IADDR,
   output logic [31:0] IDATA,
   output logic        HLT,
   output logic        DONE,
   output logic [15:0] ISSUED_CNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     idata_q, idata_d;
   logic            ld_err_q, ld_err_d;
   logic            ld_ready_q, ld_ready_d;
   logic [15:0]     issued_q, issued_d;
   logic            wr_en;
   logic [31:0]     wr_word;
   logic [31:0]     mem_q [DEPTH];

   logic [31:0]     offset;
   logic [31:0]     idx;
   logic            aligned;
   logic            above;
   logic            hit;
   logic            past_end;
   logic            legal;
   logic            accept;

   assign wr_word  = {LD_FUNCT7, LD_RS2, LD_RS1, LD_FUNCT3, LD_RD, 7'b0110011};
   assign legal    = (LD_FUNCT7 == 7'h00) ||
                     ((LD_FUNCT7 == 7'h20) && ((LD_FUNCT3 == 3'b000) || (LD_FUNCT3 == 3'b101)));
   assign accept   = LD_VALID && ld_ready_q;

   assign offset   = IADDR - BASE_ADDR;
   assign idx      = offset >> 2;
   assign aligned  = (IADDR[1:0] == 2'b00);
   assign above    = (IADDR >= BASE_ADDR);
   assign hit      = aligned && above && (idx < {{(32-CW){1'b0}}, count_q});
   assign past_end = aligned && above && !hit;

   // Next-state, load handling and fetch decode; RESTART overrides everything.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      idata_d  = NOP_WORD;
      ld_err_d = 1'b0;
      issued_d = issued_q;
      wr_en    = 1'b0;
      if (RESTART) begin
         state_d  = ST_LOAD;
         count_d  = '0;
         issued_d = '0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (accept) begin
                  if (legal) begin
                     wr_en   = 1'b1;
                     count_d = count_q + CW'(1);
                  end else begin
                     ld_err_d = 1'b1;
                  end
                  // An illegal LAST entry still ends the load phase.
                  if (LD_LAST || (legal && (count_q == CW'(DEPTH - 1))))
                     state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (hit) begin
                  idata_d = mem_q[idx[AW-1:0]];
                  if (issued_q != 16'hFFFF)
                     issued_d = issued_q + 16'd1;
               end else if (past_end) begin
                  state_d = ST_DONE;
               end
            end
            default: ;
         endcase
      end
      ld_ready_d = (state_d == ST_LOAD) && (count_d < CW'(DEPTH));
   end

   // Control and output registers.
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         state_q    <= ST_LOAD;
         count_q    <= '0;
         idata_q    <= NOP_WORD;
         ld_err_q   <= 1'b0;
         ld_ready_q <= 1'b0;
         issued_q   <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idata_q    <= idata_d;
         ld_err_q   <= ld_err_d;
         ld_ready_q <= ld_ready_d;
         issued_q   <= issued_d;
      end
   end

   // Program storage; contents are not reset since count gates every read.
   always_ff @(posedge CLK) begin
      if (wr_en)
         mem_q[count_q[AW-1:0]] <= wr_word;
   end

   assign LD_READY   = ld_ready_q;
   assign LD_ERR     = ld_err_q;
   assign IDATA      = idata_q;
   assign HLT        = (state_q == ST_LOAD);
   assign DONE       = (state_q == ST_DONE);
   assign ISSUED_CNT = issued_q;

endmodule

// File: tb/tb_r_type_instr_feeder.sv
// Directed bench for r_type_instr_feeder: loads small programs, fetches
// from them and checks the registered outputs against hand-computed words.
module tb_r_type_instr_feeder;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ADD3 = 32'h0020_81B3;   // add x3,x1,x2
   localparam logic [31:0] SUB5 = 32'h4073_02B3;   // sub x5,x6,x7
   localparam logic [31:0] ADD0 = 32'h0020_8033;   // add x0,x1,x2
   localparam logic [31:0] ADDF = 32'h0020_87B3;   // add x15,x1,x2

   logic        CLK = 1'b0;
   logic        RES_N;
   logic        LD_VALID;
   logic        LD_READY;
   logic [6:0]  LD_FUNCT7;
   logic [2:0]  LD_FUNCT3;
   logic [4:0]  LD_RS1, LD_RS2, LD_RD;
   logic        LD_LAST;
   logic        LD_ERR;
   logic        RESTART;
   logic [31:0] IADDR;
   logic [31:0] IDATA;
   logic        HLT;
   logic        DONE;
   logic [15:0] ISSUED_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   r_type_instr_feeder dut (
      .CLK(CLK), .RES_N(RES_N),
      .LD_VALID(LD_VALID), .LD_READY(LD_READY),
      .LD_FUNCT7(LD_FUNCT7), .LD_FUNCT3(LD_FUNCT3),
      .LD_RS1(LD_RS1), .LD_RS2(LD_RS2), .LD_RD(LD_RD),
      .LD_LAST(LD_LAST), .LD_ERR(LD_ERR), .RESTART(RESTART),
      .IADDR(IADDR), .IDATA(IDATA), .HLT(HLT), .DONE(DONE),
      .ISSUED_CNT(ISSUED_CNT)
   );

   always #5 CLK = ~CLK;

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic last);
      LD_FUNCT7 = f7; LD_FUNCT3 = f3; LD_RS1 = rs1; LD_RS2 = rs2; LD_RD = rd;
      LD_LAST = last; LD_VALID = 1'b1;
      step();
      LD_VALID = 1'b0; LD_LAST = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a);
      IADDR = a;
      step();
      IADDR = 32'h2;
   endtask

   task automatic do_restart();
      RESTART = 1'b1;
      step();
      RESTART = 1'b0;
      IADDR   = 32'h2;
   endtask

   task automatic test_reset();
      n_checks++; if (HLT !== 1'b1) begin n_fail++; $display("FAIL reset_hlt got %b exp 1", HLT); end
      n_checks++; if (IDATA !== NOP) begin n_fail++; $display("FAIL reset_idata got %h exp %h", IDATA, NOP); end
      n_checks++; if (LD_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", LD_READY); end
      n_checks++; if (DONE !== 1'b0 || LD_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_done_err got %b%b exp 00", DONE, LD_ERR); end
      n_checks++; if (ISSUED_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_issued got %0d exp 0", ISSUED_CNT); end
      RES_N = 1'b1;
      step();
      n_checks++; if (LD_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got %b exp 1", LD_READY); end
   endtask

   task automatic test_single_add();
      load(7'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
      n_checks++; if (HLT !== 1'b0 || LD_READY !== 1'b0) begin n_fail++; $display("FAIL single_run got hlt=%b rdy=%b exp 0 0", HLT, LD_READY); end
      fetch(32'h0);
      n_checks++; if (IDATA !== ADD3) begin n_fail++; $display("FAIL single_idata got %h exp %h", IDATA, ADD3); end
      n_checks++; if (ISSUED_CNT !== 16'd1) begin n_fail++; $display("FAIL single_issued got %0d exp 1", ISSUED_CNT); end
   endtask

   task automatic test_back_to_back();
      do_restart();
      load(7'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0);
      load(7'h20, 3'd0, 5'd6, 5'd7, 5'd5, 1'b1);
      IADDR = 32'h4; step();
      n_checks++; if (IDATA !== SUB5) begin n_fail++; $display("FAIL b2b_w1 got %h exp %h", IDATA, SUB5); end
      IADDR = 32'h0; step();
      n_checks++; if (IDATA !== ADD3) begin n_fail++; $display("FAIL b2b_w0 got %h exp %h", IDATA, ADD3); end
      IADDR = 32'h4; step();
      n_checks++; if (IDATA !== SUB5) begin n_fail++; $display("FAIL b2b_w1_again got %h exp %h", IDATA, SUB5); end
      IADDR = 32'h2; step();
      n_checks++; if (ISSUED_CNT !== 16'd3) begin n_fail++; $display("FAIL b2b_issued got %0d exp 3", ISSUED_CNT); end
   endtask

   task automatic test_illegal();
      do_restart();
      load(7'h20, 3'd1, 5'd1, 5'd2, 5'd3, 1'b0);
      n_checks++; if (LD_ERR !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b exp 1", LD_ERR); end
      step();
      n_checks++; if (LD_ERR !== 1'b0 || HLT !== 1'b1) begin n_fail++; $display("FAIL illegal_err_pulse got err=%b hlt=%b exp 0 1", LD_ERR, HLT); end
      load(7'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b0);
      load(7'h01, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
      n_checks++; if (LD_ERR !== 1'b1 || HLT !== 1'b0) begin n_fail++; $display("FAIL illegal_last got err=%b hlt=%b exp 1 0", LD_ERR, HLT); end
      fetch(32'h0);
      n_checks++; if (IDATA !== ADD3) begin n_fail++; $display("FAIL illegal_idx0 got %h exp %h", IDATA, ADD3); end
      fetch(32'h4);
      n_checks++; if (IDATA !== NOP || DONE !== 1'b1) begin n_fail++; $display("FAIL illegal_end got %h done=%b exp %h 1", IDATA, DONE, NOP); end
   endtask

   task automatic test_full_depth();
      do_restart();
      for (int i = 0; i < 16; i++) load(7'h00, 3'd0, 5'd1, 5'd2, 5'(i), 1'b0);
      n_checks++; if (LD_READY !== 1'b0 || HLT !== 1'b0) begin n_fail++; $display("FAIL full_run got rdy=%b hlt=%b exp 0 0", LD_READY, HLT); end
      fetch(32'h2);
      n_checks++; if (IDATA !== NOP || DONE !== 1'b0) begin n_fail++; $display("FAIL full_misaligned got %h done=%b exp %h 0", IDATA, DONE, NOP); end
      fetch(32'h0);
      n_checks++; if (IDATA !== ADD0) begin n_fail++; $display("FAIL full_w0 got %h exp %h", IDATA, ADD0); end
      fetch(32'h3C);
      n_checks++; if (IDATA !== ADDF) begin n_fail++; $display("FAIL full_w15 got %h exp %h", IDATA, ADDF); end
      fetch(32'h40);
      n_checks++; if (IDATA !== NOP || DONE !== 1'b1) begin n_fail++; $display("FAIL full_end got %h done=%b exp %h 1", IDATA, DONE, NOP); end
      fetch(32'h0);
      n_checks++; if (IDATA !== NOP || ISSUED_CNT !== 16'd2) begin n_fail++; $display("FAIL full_frozen got %h cnt=%0d exp %h 2", IDATA, ISSUED_CNT, NOP); end
   endtask

   task automatic test_async_reset();
      do_restart();
      load(7'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
      fetch(32'h0);
      n_checks++; if (ISSUED_CNT !== 16'd1) begin n_fail++; $display("FAIL areset_pre got %0d exp 1", ISSUED_CNT); end
      #2 RES_N = 1'b0;
      #1;
      n_checks++; if (HLT !== 1'b1 || IDATA !== NOP) begin n_fail++; $display("FAIL areset_out got hlt=%b idata=%h exp 1 %h", HLT, IDATA, NOP); end
      n_checks++; if (DONE !== 1'b0 || ISSUED_CNT !== 16'd0 || LD_READY !== 1'b0) begin n_fail++; $display("FAIL areset_ctl got done=%b cnt=%0d rdy=%b exp 0 0 0", DONE, ISSUED_CNT, LD_READY); end
      RES_N = 1'b1;
      step();
      n_checks++; if (LD_READY !== 1'b1 || HLT !== 1'b1) begin n_fail++; $display("FAIL areset_release got rdy=%b hlt=%b exp 1 1", LD_READY, HLT); end
   endtask

   task automatic test_restart();
      load(7'h00, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1);
      fetch(32'h4);
      n_checks++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL restart_enter_done got %b exp 1", DONE); end
      RESTART = 1'b1;
      load(7'h20, 3'd0, 5'd6, 5'd7, 5'd5, 1'b1);
      RESTART = 1'b0;
      n_checks++; if (HLT !== 1'b1 || DONE !== 1'b0 || IDATA !== NOP || ISSUED_CNT !== 16'd0) begin n_fail++; $display("FAIL restart_from_done got hlt=%b done=%b idata=%h cnt=%0d exp 1 0 %h 0", HLT, DONE, IDATA, ISSUED_CNT, NOP); end
      RESTART = 1'b1;
      load(7'h20, 3'd0, 5'd6, 5'd7, 5'd5, 1'b1);
      RESTART = 1'b0;
      n_checks++; if (HLT !== 1'b1 || LD_READY !== 1'b1 || LD_ERR !== 1'b0) begin n_fail++; $display("FAIL restart_priority got hlt=%b rdy=%b err=%b exp 1 1 0", HLT, LD_READY, LD_ERR); end
      load(7'h20, 3'd0, 5'd6, 5'd7, 5'd5, 1'b1);
      fetch(32'h0);
      n_checks++; if (IDATA !== SUB5 || ISSUED_CNT !== 16'd1) begin n_fail++; $display("FAIL restart_reload got %h cnt=%0d exp %h 1", IDATA, ISSUED_CNT, SUB5); end
      fetch(32'h4);
      n_checks++; if (DONE !== 1'b1) begin n_fail++; $display("FAIL restart_reload_end got %b exp 1", DONE); end
   endtask

   initial begin
      RES_N = 1'b0; LD_VALID = 1'b0; LD_LAST = 1'b0; RESTART = 1'b0;
      LD_FUNCT7 = '0; LD_FUNCT3 = '0; LD_RS1 = '0; LD_RS2 = '0; LD_RD = '0;
      IADDR = 32'h2;
      step();
      test_reset();
      test_single_add();
      test_back_to_back();
      test_illegal();
      test_full_depth();
      test_async_reset();
      test_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
